// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) round-robin arbiter onto a single RAM port
// Three-state FSM (IDLE/ACCESS/DONE) with registered outputs and a per-access wait timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_done,
  output logic [31:0] d_rdata,

  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [1:0]  ram_size,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,

  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic       last_grant;   // 1 = data port won the previous grant
  logic       cur_data;     // 1 = transaction in flight belongs to the data port
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       data_wins;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    data_wins = d_req && (!if_req || !last_grant);
    wait_next = wait_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_data    <= 1'b0;
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_addr    <= 32'd0;
      ram_wdata   <= 32'd0;
      ram_size    <= 2'b00;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      if_rdata    <= 32'd0;
      d_rdata     <= 32'd0;
      busy        <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            ram_cs     <= 1'b1;
            wait_cnt   <= 8'd0;
            last_grant <= data_wins;
            cur_data   <= data_wins;
            if (data_wins) begin
              ram_we    <= d_we;
              ram_oe    <= !d_we;
              ram_addr  <= d_addr;
              ram_size  <= d_size;
              ram_wdata <= d_wdata;
            end else begin
              ram_we    <= 1'b0;
              ram_oe    <= 1'b1;
              ram_addr  <= if_addr & 32'hFFFF_FFFC;
              ram_size  <= 2'b10;
              ram_wdata <= 32'd0;
            end
          end
        end

        ACCESS: begin
          // ram_ready wins over a timeout landing on the same edge.
          if (ram_ready || (wait_next == TIMEOUT_CNT)) begin
            state   <= DONE;
            ram_cs  <= 1'b0;
            ram_we  <= 1'b0;
            ram_oe  <= 1'b0;
            if_done <= !cur_data;
            d_done  <= cur_data;
            if (ram_ready) begin
              if (!cur_data)
                if_rdata <= ram_rdata;
              else if (!ram_we)
                d_rdata <= ram_rdata;
            end else begin
              timeout_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_next;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector table plus multi-cycle sequences for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [1:0]  ram_size;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_size      (d_size),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .ram_cs      (ram_cs),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_size    (ram_size),
    .ram_rdata   (ram_rdata),
    .ram_ready   (ram_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic [31:0] rram;
    logic        rdy;
    logic        e_cs;
    logic        e_we;
    logic        e_oe;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic        chk_wd;
    logic [31:0] e_wdata;
    logic        e_ifd;
    logic [31:0] e_ifr;
    logic        e_dd;
    logic [31:0] e_dr;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'd0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'd0;
    d_wdata   = 32'd0;
    d_size    = 2'b00;
    ram_rdata = 32'd0;
    ram_ready = 1'b0;
  endtask

  localparam logic [31:0] FW = 32'hE3A0_1005;

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            rst if  if_addr   dq we d_addr     d_wdata   sz rram            rdy cs we oe e_addr     sz cw e_wdata   ifd e_ifr dd e_dr           bsy err
    vecs[0]  = '{1, 0, 32'h0,     0, 0, 32'h0,     32'h0,    0, 32'h0,         0,  0, 0, 0, 32'h0,     0, 1, 32'h0,    0,  32'h0, 0, 32'h0,         0, 0};
    vecs[1]  = '{0, 1, 32'h106,   0, 0, 32'h0,     32'h0,    0, 32'h0,         0,  1, 0, 1, 32'h104,   2, 0, 32'h0,    0,  32'h0, 0, 32'h0,         1, 0};
    vecs[2]  = '{0, 1, 32'h106,   0, 0, 32'h0,     32'h0,    0, 32'h0,         0,  1, 0, 1, 32'h104,   2, 0, 32'h0,    0,  32'h0, 0, 32'h0,         1, 0};
    vecs[3]  = '{0, 1, 32'h106,   0, 0, 32'h0,     32'h0,    0, 32'h0,         0,  1, 0, 1, 32'h104,   2, 0, 32'h0,    0,  32'h0, 0, 32'h0,         1, 0};
    vecs[4]  = '{0, 1, 32'h106,   0, 0, 32'h0,     32'h0,    0, FW,            1,  0, 0, 0, 32'h104,   2, 0, 32'h0,    1,  FW,    0, 32'h0,         1, 0};
    vecs[5]  = '{0, 0, 32'h0,     0, 0, 32'h0,     32'h0,    0, 32'h0,         0,  0, 0, 0, 32'h104,   2, 0, 32'h0,    0,  FW,    0, 32'h0,         0, 0};
    vecs[6]  = '{0, 0, 32'h0,     1, 1, 32'h2003,  32'hAB,   0, 32'h0,         0,  1, 1, 0, 32'h2003,  0, 1, 32'hAB,   0,  FW,    0, 32'h0,         1, 0};
    vecs[7]  = '{0, 0, 32'h0,     1, 1, 32'h2003,  32'hAB,   0, 32'hDEADBEEF,  1,  0, 0, 0, 32'h2003,  0, 1, 32'hAB,   0,  FW,    1, 32'h0,         1, 0};
    vecs[8]  = '{0, 0, 32'h0,     0, 0, 32'h0,     32'h0,    0, 32'h12345678,  1,  0, 0, 0, 32'h2003,  0, 1, 32'hAB,   0,  FW,    0, 32'h0,         0, 0};
    vecs[9]  = '{0, 0, 32'h0,     0, 0, 32'h0,     32'h0,    0, 32'h87654321,  1,  0, 0, 0, 32'h2003,  0, 1, 32'hAB,   0,  FW,    0, 32'h0,         0, 0};
    vecs[10] = '{0, 0, 32'h0,     1, 0, 32'h3002,  32'h1234, 1, 32'h0,         0,  1, 0, 1, 32'h3002,  1, 1, 32'h1234, 0,  FW,    0, 32'h0,         1, 0};
    vecs[11] = '{0, 0, 32'h0,     0, 0, 32'h0,     32'h0,    0, 32'h5555AAAA,  1,  0, 0, 0, 32'h3002,  1, 1, 32'h1234, 0,  FW,    1, 32'h5555AAAA,  1, 0};
    vecs[12] = '{0, 0, 32'h0,     0, 0, 32'h0,     32'h0,    0, 32'h0,         0,  0, 0, 0, 32'h3002,  1, 1, 32'h1234, 0,  FW,    0, 32'h5555AAAA,  0, 0};

    for (int i = 0; i < NV; i++) begin
      rst       = vecs[i].rst;
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      d_req     = vecs[i].d_req;
      d_we      = vecs[i].d_we;
      d_addr    = vecs[i].d_addr;
      d_wdata   = vecs[i].d_wdata;
      d_size    = vecs[i].d_size;
      ram_rdata = vecs[i].rram;
      ram_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d ram_cs", i),      {31'd0, ram_cs},      {31'd0, vecs[i].e_cs});
      chk($sformatf("v%0d ram_we", i),      {31'd0, ram_we},      {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d ram_oe", i),      {31'd0, ram_oe},      {31'd0, vecs[i].e_oe});
      chk($sformatf("v%0d ram_addr", i),    ram_addr,             vecs[i].e_addr);
      chk($sformatf("v%0d ram_size", i),    {30'd0, ram_size},    {30'd0, vecs[i].e_size});
      if (vecs[i].chk_wd)
        chk($sformatf("v%0d ram_wdata", i), ram_wdata,            vecs[i].e_wdata);
      chk($sformatf("v%0d if_done", i),     {31'd0, if_done},     {31'd0, vecs[i].e_ifd});
      chk($sformatf("v%0d if_rdata", i),    if_rdata,             vecs[i].e_ifr);
      chk($sformatf("v%0d d_done", i),      {31'd0, d_done},      {31'd0, vecs[i].e_dd});
      chk($sformatf("v%0d d_rdata", i),     d_rdata,              vecs[i].e_dr);
      chk($sformatf("v%0d busy", i),        {31'd0, busy},        {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d timeout_err", i), {31'd0, timeout_err}, {31'd0, vecs[i].e_err});
    end

    // Tie after reset: fetch, data, fetch, data, each ACCESS/DONE/IDLE.
    rst = 1'b1;
    idle_inputs();
    tick();
    rst       = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h1003;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h2001;
    d_size    = 2'b10;
    ram_ready = 1'b1;
    ram_rdata = 32'hCAFE0000;
    for (int i = 0; i < 12; i++) begin
      int   ph;
      logic exp_data;
      ph       = i % 3;
      exp_data = ((i / 3) % 2) == 1;
      tick();
      chk($sformatf("tie%0d ram_cs", i),  {31'd0, ram_cs},  {31'd0, ph == 0});
      chk($sformatf("tie%0d busy", i),    {31'd0, busy},    {31'd0, ph != 2});
      chk($sformatf("tie%0d if_done", i), {31'd0, if_done}, {31'd0, (ph == 1) && !exp_data});
      chk($sformatf("tie%0d d_done", i),  {31'd0, d_done},  {31'd0, (ph == 1) && exp_data});
      if (ph == 0)
        chk($sformatf("tie%0d grant addr", i), ram_addr, exp_data ? 32'h2001 : 32'h1000);
    end
    idle_inputs();
    tick();

    // Timeout with TIMEOUT=4 and ram_ready never asserted.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h40;
    d_size    = 2'b10;
    ram_rdata = 32'h77;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to acc%0d ram_cs", i), {31'd0, ram_cs},      32'd1);
      chk($sformatf("to acc%0d d_done", i), {31'd0, d_done},      32'd0);
      chk($sformatf("to acc%0d err", i),    {31'd0, timeout_err}, 32'd0);
    end
    tick();
    chk("to abort ram_cs",  {31'd0, ram_cs},      32'd0);
    chk("to abort d_done",  {31'd0, d_done},      32'd1);
    chk("to abort err",     {31'd0, timeout_err}, 32'd1);
    chk("to abort d_rdata", d_rdata,              32'd0);
    d_req = 1'b0;
    tick();
    chk("to idle d_done", {31'd0, d_done},      32'd0);
    chk("to idle busy",   {31'd0, busy},        32'd0);
    chk("to idle err",    {31'd0, timeout_err}, 32'd1);
    if_req    = 1'b1;
    if_addr   = 32'h80;
    ram_ready = 1'b1;
    ram_rdata = 32'h99;
    tick();
    tick();
    chk("to ok if_done",  {31'd0, if_done},     32'd1);
    chk("to ok if_rdata", if_rdata,             32'h99);
    chk("to ok err",      {31'd0, timeout_err}, 32'd1);
    idle_inputs();
    tick();
    chk("to sticky err", {31'd0, timeout_err}, 32'd1);

    // ram_ready on the edge the counter would reach TIMEOUT is a success.
    rst = 1'b1;
    tick();
    chk("rst clears err", {31'd0, timeout_err}, 32'd0);
    rst       = 1'b0;
    d_req     = 1'b1;
    d_addr    = 32'h44;
    d_size    = 2'b10;
    ram_rdata = 32'h5A5A;
    tick();
    tick();
    tick();
    tick();
    chk("edge still access", {31'd0, ram_cs}, 32'd1);
    ram_ready = 1'b1;
    tick();
    chk("edge d_done",  {31'd0, d_done},      32'd1);
    chk("edge err",     {31'd0, timeout_err}, 32'd0);
    chk("edge d_rdata", d_rdata,              32'h5A5A);
    idle_inputs();
    tick();

    // Reset on the second ACCESS cycle of a data read.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h50;
    tick();
    tick();
    chk("rsta acc2 ram_cs", {31'd0, ram_cs}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rsta ram_cs", {31'd0, ram_cs}, 32'd0);
    chk("rsta d_done", {31'd0, d_done}, 32'd0);
    chk("rsta busy",   {31'd0, busy},   32'd0);
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h64;
    tick();
    chk("rsta tie ram_cs",   {31'd0, ram_cs}, 32'd1);
    chk("rsta tie to fetch", ram_addr,        32'h64);
    chk("rsta tie d_done",   {31'd0, d_done}, 32'd0);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS cycles before the access is aborted; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 if_req  in  1  instruction-fetch request; held high until if_done.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_done  out  1  one-cycle completion pulse for fetch.
REQ-007 if_rdata  out  32  fetched word; valid while if_done=1, held until the next fetch completes.
REQ-008 d_req  in  1  data request; held high until d_done.
REQ-009 d_we  in  1  1 = write, 0 = read.
REQ-010 d_addr  in  32  data byte address.
REQ-011 d_wdata  in  32  write data.
REQ-012 d_size  in  2  00 byte, 01 halfword, 10 word.
REQ-013 d_done  out  1  one-cycle completion pulse for data.
REQ-014 d_rdata  out  32  read data; valid while d_done=1, held until the next data read completes.
REQ-015 ram_cs, ram_we, ram_oe  out  1 each  RAM strobes.
REQ-016 ram_addr  out  32  RAM address.
REQ-017 ram_wdata  out  32  RAM write data.
REQ-018 ram_size  out  2  RAM access size.
REQ-019 ram_rdata  in  32  RAM read data.
REQ-020 ram_ready  in  1  RAM completion, sampled only in ACCESS.
REQ-021 busy  out  1  high in ACCESS and DONE.
REQ-022 timeout_err  out  1  sticky abort flag.

Function
REQ-023 The FSM SHALL have exactly three states, IDLE, ACCESS and DONE, and all outputs SHALL be registered.
REQ-024 In IDLE with any request high, the block SHALL latch the winner's address, size, we and wdata and go to ACCESS at the next edge.
REQ-025 Arbitration SHALL behave as follows:
- Single request: that requester wins.
- Both requests high: the requester not granted last wins (round-robin).
- The last_grant bit SHALL update on every grant.
REQ-026 For a fetch, the block SHALL drive ram_addr = {if_addr[31:2],2'b00}, ram_size = 10 and ram_we = 0.
REQ-027 For a data access, the block SHALL drive ram_addr = d_addr and ram_size = d_size, and SHALL pass ram_wdata unaligned.
REQ-028 In ACCESS the block SHALL drive ram_cs = 1, ram_we = latched we and ram_oe = ~latched we; in IDLE and DONE all strobes SHALL be 0.
REQ-029 Request inputs SHALL NOT affect the latched transaction; dropping req during ACCESS SHALL NOT cancel it.
REQ-030 When ram_ready = 1 is sampled in ACCESS, the block SHALL capture ram_rdata into the granted requester's rdata register (reads only), go to DONE and pulse that requester's done for exactly one cycle.
REQ-031 From DONE the FSM SHALL always return to IDLE; a req still high in IDLE SHALL start a new access, giving a minimum of 3 cycles per transaction.
REQ-032 Minimum latency SHALL be: req sampled at edge k gives ram_cs high after k; ram_ready at edge k+1 gives done high after k+1.
REQ-033 An 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with ram_ready = 0.
REQ-034 When the wait counter reaches TIMEOUT, the block SHALL go to DONE, pulse done, leave rdata unchanged and set timeout_err.
REQ-035 ram_ready = 1 on the same edge the counter reaches TIMEOUT SHALL count as success, with no error.
REQ-036 timeout_err SHALL clear only on rst.
REQ-037 ram_ready outside ACCESS SHALL be ignored.

Reset
REQ-038 While rst = 1 at an edge, the block SHALL set:
- FSM to IDLE and last_grant to data, so that fetch wins the first tie.
- Wait counter and timeout_err to 0.
- All strobes, done pulses, busy and rdata registers to 0; ram_addr, ram_wdata and ram_size to 0.
REQ-039 Reset during ACCESS SHALL drop ram_cs after that edge with no done pulse.

Verification
REQ-040 Fetch only: if_addr = 0x0000_0106, RAM ready after 2 wait cycles, ram_rdata = 0xE3A0_1005 -> ram_addr = 0x0000_0104, ram_oe = 1, ram_size = 10; if_done for 1 cycle with if_rdata = 0xE3A0_1005.
REQ-041 Data byte write: d_addr = 0x0000_2003, d_wdata = 0xAB, d_size = 00, d_we = 1, ready immediate -> ram_we = 1, ram_oe = 0, ram_size = 00; d_done after 2 edges; d_rdata unchanged.
REQ-042 Tie after reset with both req held -> grant order fetch, data, fetch, data; each ACCESS separated by DONE and IDLE cycles.
REQ-043 TIMEOUT = 4, ram_ready never asserted -> the block SHALL do all of the following:
- Abort after 4 ACCESS cycles.
- Pulse done once.
- Set timeout_err and keep it high through later successful accesses until rst.
REQ-044 rst asserted on the 2nd ACCESS cycle of a data read -> ram_cs = 0 next cycle, no d_done, busy = 0, and the next tie goes to fetch.
